// File: rtl/lab_output_block_if.sv
// Signal bundle between a LAB output block and the logic that drives it:
// macrocell terms and configuration stream in, macrocell outputs and load status out.
interface lab_output_block_if #(
  parameter int MACROCELL_COUNT = 16
);
  logic [MACROCELL_COUNT-1:0] sum_term;
  logic [MACROCELL_COUNT-1:0] secondary_term;
  logic [MACROCELL_COUNT-1:0] clock_enable;
  logic [MACROCELL_COUNT-1:0] sync_clear;
  logic [MACROCELL_COUNT-1:0] sync_preset;
  logic                       cfg_shift_en;
  logic                       cfg_data_in;
  logic                       cfg_commit;
  logic [MACROCELL_COUNT-1:0] pia_feedback;
  logic [MACROCELL_COUNT-1:0] io_out;
  logic                       cfg_done;
  logic                       cfg_error;

  modport master (
    output sum_term, secondary_term, clock_enable, sync_clear, sync_preset,
    output cfg_shift_en, cfg_data_in, cfg_commit,
    input  pia_feedback, io_out, cfg_done, cfg_error
  );

  modport slave (
    input  sum_term, secondary_term, clock_enable, sync_clear, sync_preset,
    input  cfg_shift_en, cfg_data_in, cfg_commit,
    output pia_feedback, io_out, cfg_done, cfg_error
  );
endinterface

// File: rtl/lab_output_block.sv
// LAB output block: per-macrocell D/T/JK/SR registers with a serially loaded, atomically
// committed configuration. Define LAB_OUTPUT_PARITY_EN for an even-parity-checked load.
module lab_output_block #(
  parameter int MACROCELL_COUNT    = 16,
  parameter int CONFIG_BITS_PER_MC = 4
) (
  input logic               clk,
  input logic               reset,
  lab_output_block_if.slave bus
);

  localparam int ConfigBitCount = MACROCELL_COUNT * CONFIG_BITS_PER_MC;
`ifdef LAB_OUTPUT_PARITY_EN
  localparam int LoadBitCount = ConfigBitCount + 1;
`else
  localparam int LoadBitCount = ConfigBitCount;
`endif
  localparam int CountWidth = $clog2(LoadBitCount + 1);
  localparam logic [CountWidth-1:0] LoadBitsC = CountWidth'(LoadBitCount);

  typedef enum logic [1:0] {IDLE, SHIFTING, READY} load_state_e;

  load_state_e                state_q, state_d;
  logic [CountWidth-1:0]      count_q, count_d, count_inc;
  logic [ConfigBitCount-1:0]  shadow_q, shadow_d;
  logic [ConfigBitCount-1:0]  active_q, active_d;
  logic [MACROCELL_COUNT-1:0] mc_q, mc_d;
  logic                       done_q, done_d;
  logic                       error_q, error_d;

  logic                       last_bit, load_ok, commit_gate;
  logic                       shadow_shift, commit_ok, error_set;
  logic [1:0]                 ff_type [MACROCELL_COUNT];
  logic [MACROCELL_COUNT-1:0] bypass, invert, out_vec;

  assign count_inc = count_q + CountWidth'(1);
  assign last_bit  = (state_q == SHIFTING) && bus.cfg_shift_en && (count_inc == LoadBitsC);

`ifdef LAB_OUTPUT_PARITY_EN
  logic parity_q, parity_d;

  // Final bit of the stream is even parity over the shadow contents it follows.
  assign load_ok     = ~(^shadow_q ^ bus.cfg_data_in);
  assign commit_gate = ~(^shadow_q ^ parity_q);
  assign parity_d    = last_bit ? bus.cfg_data_in : parity_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) parity_q <= 1'b0;
    else       parity_q <= parity_d;
  end
`else
  assign load_ok     = 1'b1;
  assign commit_gate = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (bus.cfg_shift_en) begin
          state_d = SHIFTING;
          count_d = CountWidth'(1);
        end
      end
      SHIFTING: begin
        if (bus.cfg_shift_en) begin
          count_d = count_inc;
          if (last_bit) begin
            if (load_ok) begin
              state_d = READY;
            end else begin
              state_d = IDLE;
              count_d = '0;
            end
          end
        end
      end
      READY: begin
        if (bus.cfg_shift_en || bus.cfg_commit) begin
          state_d = IDLE;
          count_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_comb begin
    shadow_shift = bus.cfg_shift_en;
    commit_ok    = 1'b0;
    error_set    = 1'b0;
`ifdef LAB_OUTPUT_PARITY_EN
    if (last_bit) shadow_shift = 1'b0;
`endif
    if (bus.cfg_commit && ((state_q != READY) || bus.cfg_shift_en)) error_set = 1'b1;
    if (bus.cfg_shift_en && (state_q == READY)) error_set = 1'b1;
    if (last_bit && !load_ok) error_set = 1'b1;
    if ((state_q == READY) && bus.cfg_commit && !bus.cfg_shift_en && commit_gate) commit_ok = 1'b1;
  end

  always_comb begin
    shadow_d = shadow_shift ? {shadow_q[ConfigBitCount-2:0], bus.cfg_data_in} : shadow_q;
    active_d = commit_ok ? shadow_q : active_q;
    done_d   = commit_ok;
    error_d  = error_q | error_set;
  end

  always_comb begin
    for (int i = 0; i < MACROCELL_COUNT; i++) begin
      ff_type[i] = active_q[CONFIG_BITS_PER_MC*i +: 2];
      bypass[i]  = active_q[CONFIG_BITS_PER_MC*i + 2];
      invert[i]  = active_q[CONFIG_BITS_PER_MC*i + 3];
    end
  end

  // Clear beats preset beats enable; the register keeps running while bypassed.
  always_comb begin
    mc_d = mc_q;
    for (int i = 0; i < MACROCELL_COUNT; i++) begin
      if (bus.sync_clear[i]) begin
        mc_d[i] = 1'b0;
      end else if (bus.sync_preset[i]) begin
        mc_d[i] = 1'b1;
      end else if (bus.clock_enable[i]) begin
        case (ff_type[i])
          2'b00: mc_d[i] = bus.sum_term[i];
          2'b01: mc_d[i] = mc_q[i] ^ bus.sum_term[i];
          2'b10: begin
            case ({bus.sum_term[i], bus.secondary_term[i]})
              2'b00:   mc_d[i] = mc_q[i];
              2'b01:   mc_d[i] = 1'b0;
              2'b10:   mc_d[i] = 1'b1;
              default: mc_d[i] = ~mc_q[i];
            endcase
          end
          default: begin
            case ({bus.sum_term[i], bus.secondary_term[i]})
              2'b00:   mc_d[i] = mc_q[i];
              2'b10:   mc_d[i] = 1'b1;
              default: mc_d[i] = 1'b0;
            endcase
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
      active_q <= '0;
      mc_q     <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      mc_q     <= mc_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign out_vec          = ((bypass & bus.sum_term) | (~bypass & mc_q)) ^ invert;
  assign bus.pia_feedback = out_vec;
  assign bus.io_out       = out_vec;
  assign bus.cfg_done     = done_q;
  assign bus.cfg_error    = error_q;

endmodule

// File: tb/tb_lab_output_block.sv
// Directed bench for lab_output_block: reset, macrocell function table, bypass path,
// and configuration-load protocol corners (early commit, overflow, reset mid-load, parity).
module tb_lab_output_block;

  logic clk = 1'b0;
  logic reset;
  int   assertions = 0;
  int   failures   = 0;

  localparam logic [63:0] CfgA = 64'h0000_0000_0008_2C31;
  localparam logic [63:0] CfgB = 64'h4444_4444_4444_4444;

  typedef struct {
    string       name;
    logic [15:0] sum;
    logic [15:0] sec;
    logic [15:0] ce;
    logic [15:0] clr;
    logic [15:0] pre;
    logic [15:0] expOut;
  } vec_t;

  vec_t vecs[15];

  lab_output_block_if #(.MACROCELL_COUNT(16)) bus ();

  lab_output_block dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [15:0] sum, input logic [15:0] sec,
                               input logic [15:0] ce, input logic [15:0] clr,
                               input logic [15:0] pre);
    bus.sum_term       = sum;
    bus.secondary_term = sec;
    bus.clock_enable   = ce;
    bus.sync_clear     = clr;
    bus.sync_preset    = pre;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic shiftBit(input logic b);
    bus.cfg_shift_en = 1'b1;
    bus.cfg_data_in  = b;
    tick();
    bus.cfg_shift_en = 1'b0;
  endtask

  task automatic shiftRange(input logic [63:0] cfg, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) shiftBit(cfg[i]);
  endtask

  task automatic loadCfg(input logic [63:0] cfg);
    shiftRange(cfg, 63, 0);
`ifdef LAB_OUTPUT_PARITY_EN
    shiftBit(^cfg);
`endif
  endtask

  task automatic commitCfg();
    bus.cfg_commit = 1'b1;
    tick();
    bus.cfg_commit = 1'b0;
  endtask

  task automatic resetDut();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Config A: mc0 T, mc1 SR, mc2 bypass+invert, mc3 JK, mc4 D inverted, rest plain D.
  initial begin
    vecs[0]  = '{"clear_all",     16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0010};
    vecs[1]  = '{"t_toggle_1",    16'h0001, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0015};
    vecs[2]  = '{"t_toggle_2",    16'h0001, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0014};
    vecs[3]  = '{"t_toggle_3",    16'h0001, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0015};
    vecs[4]  = '{"sr_set",        16'h0002, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0017};
    vecs[5]  = '{"sr_both_reset", 16'h0002, 16'h0002, 16'hFFFF, 16'h0000, 16'h0000, 16'h0015};
    vecs[6]  = '{"jk_set",        16'h0008, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h001D};
    vecs[7]  = '{"jk_toggle_1",   16'h0008, 16'h0008, 16'hFFFF, 16'h0000, 16'h0000, 16'h0015};
    vecs[8]  = '{"jk_toggle_2",   16'h0008, 16'h0008, 16'hFFFF, 16'h0000, 16'h0000, 16'h001D};
    vecs[9]  = '{"jk_reset",      16'h0000, 16'h0008, 16'hFFFF, 16'h0000, 16'h0000, 16'h0015};
    vecs[10] = '{"ce_low_hold",   16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0011};
    vecs[11] = '{"preset_no_ce",  16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFEF};
    vecs[12] = '{"clr_beats_pre", 16'h0000, 16'h0000, 16'h0000, 16'h0002, 16'h0002, 16'hFFED};
    vecs[13] = '{"d_pattern",     16'hA5A0, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'hA5BD};
    vecs[14] = '{"partial_ce",    16'h0000, 16'h0000, 16'h00FF, 16'h0000, 16'h0000, 16'hA51D};

    reset            = 1'b1;
    bus.cfg_shift_en = 1'b0;
    bus.cfg_data_in  = 1'b0;
    bus.cfg_commit   = 1'b0;
    applyStimulus(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tick();
    tick();
    checkOutput("reset_pia", bus.pia_feedback, 16'h0000);
    checkOutput("reset_io", bus.io_out, 16'h0000);
    checkOutput("reset_done", {15'b0, bus.cfg_done}, 16'h0000);
    checkOutput("reset_error", {15'b0, bus.cfg_error}, 16'h0000);

    reset = 1'b0;
    applyStimulus(16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000);
    #1;
    checkOutput("d_before_edge", bus.pia_feedback, 16'h0000);
    tick();
    checkOutput("d_after_edge", bus.pia_feedback, 16'hFFFF);

    loadCfg(CfgA);
    checkOutput("no_early_done", {15'b0, bus.cfg_done}, 16'h0000);
    commitCfg();
    checkOutput("commit_done", {15'b0, bus.cfg_done}, 16'h0001);
    checkOutput("commit_no_error", {15'b0, bus.cfg_error}, 16'h0000);
    checkOutput("commit_new_cfg", bus.pia_feedback, 16'hFFEB);
    tick();
    checkOutput("done_one_cycle", {15'b0, bus.cfg_done}, 16'h0000);

    for (int v = 0; v < 15; v++) begin
      applyStimulus(vecs[v].sum, vecs[v].sec, vecs[v].ce, vecs[v].clr, vecs[v].pre);
      tick();
      checkOutput(vecs[v].name, bus.pia_feedback, vecs[v].expOut);
      checkOutput({vecs[v].name, "_io"}, bus.io_out, vecs[v].expOut);
    end

    // mc2 bypass path must follow sum_term with no clock edge in between
    bus.sum_term = 16'h0000;
    #1;
    checkOutput("bypass_low", {15'b0, bus.pia_feedback[2]}, 16'h0001);
    bus.sum_term = 16'h0004;
    #1;
    checkOutput("bypass_high", {15'b0, bus.pia_feedback[2]}, 16'h0000);

    // Overflow: a 65th shift while READY aborts the load and flags an error
    resetDut();
    applyStimulus(16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000);
    checkOutput("rst2_pia", bus.pia_feedback, 16'h0000);
    checkOutput("rst2_error", {15'b0, bus.cfg_error}, 16'h0000);
    loadCfg(CfgB);
    checkOutput("full_load_no_error", {15'b0, bus.cfg_error}, 16'h0000);
    shiftBit(1'b0);
    checkOutput("overflow_error", {15'b0, bus.cfg_error}, 16'h0001);
    commitCfg();
    checkOutput("overflow_no_done", {15'b0, bus.cfg_done}, 16'h0000);
    bus.sum_term = 16'hFFFF;
    #1;
    checkOutput("overflow_active_kept", bus.pia_feedback, 16'h0000);

    // Reset mid-load, then an early commit that must not disturb the shifting load
    shiftRange(CfgB, 63, 44);
    resetDut();
    applyStimulus(16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000);
    checkOutput("midload_rst_error", {15'b0, bus.cfg_error}, 16'h0000);
    shiftRange(CfgB, 63, 54);
    commitCfg();
    checkOutput("early_commit_error", {15'b0, bus.cfg_error}, 16'h0001);
    checkOutput("early_commit_no_done", {15'b0, bus.cfg_done}, 16'h0000);
    shiftRange(CfgB, 53, 0);
`ifdef LAB_OUTPUT_PARITY_EN
    shiftBit(^CfgB);
`endif
    commitCfg();
    checkOutput("resumed_load_done", {15'b0, bus.cfg_done}, 16'h0001);
    checkOutput("error_sticky", {15'b0, bus.cfg_error}, 16'h0001);
    bus.sum_term = 16'h1234;
    #1;
    checkOutput("cfg_b_bypass_pia", bus.pia_feedback, 16'h1234);
    checkOutput("cfg_b_bypass_io", bus.io_out, 16'h1234);

`ifdef LAB_OUTPUT_PARITY_EN
    resetDut();
    applyStimulus(16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000);
    shiftRange(CfgB, 63, 0);
    shiftBit(~(^CfgB));
    checkOutput("bad_parity_error", {15'b0, bus.cfg_error}, 16'h0001);
    commitCfg();
    checkOutput("bad_parity_no_done", {15'b0, bus.cfg_done}, 16'h0000);
    resetDut();
    loadCfg(CfgB);
    commitCfg();
    checkOutput("good_parity_done", {15'b0, bus.cfg_done}, 16'h0001);
    checkOutput("good_parity_no_error", {15'b0, bus.cfg_error}, 16'h0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
